// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, arbiter state encoding and requester IDs (FL=0, DM=1, IF=2)
package proc_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {REQ_FL = 2'd0, REQ_DM = 2'd1, REQ_IF = 2'd2, REQ_NONE = 2'd3} req_id_t;
endpackage

// File: rtl/prio_select.sv
// prio_select: one-hot grant {if,dm,fl}; fixed fl>dm>if, but if beats dm right after a dm grant
module prio_select import proc_pkg::*; (
  input  logic       fl_req,
  input  logic       dm_req,
  input  logic       if_req,
  input  req_id_t    last_grant,
  output logic [2:0] grant
);
  logic if_turn;
  always_comb begin
    if_turn = (last_grant == REQ_DM) & if_req;
    grant = {~fl_req & if_req & (~dm_req | if_turn), ~fl_req & dm_req & ~if_turn, fl_req};
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port among file-loader, data and fetch requesters; IDLE->ACCESS->RESP, one valid pulse per access, stall for dm/if
module mem_arbiter import proc_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fl_req,
  input  logic              fl_we,
  input  logic [ADDR_W-1:0] fl_addr,
  input  logic [DATA_W-1:0] fl_wdata,
  output logic              fl_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall
);
  state_t state;
  req_id_t last, cur, win;
  logic [2:0] grant, valid_q;
  logic we_q;
  prio_select u_prio (.fl_req(fl_req), .dm_req(dm_req), .if_req(if_req), .last_grant(last), .grant(grant));
  always_comb win = grant[0] ? REQ_FL : grant[1] ? REQ_DM : REQ_IF;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= REQ_NONE;
      cur <= REQ_NONE;
      we_q <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      valid_q <= '0;
    end else begin
      we_q <= 1'b0;
      valid_q <= '0;
      case (state)
        IDLE: if (|grant) begin
          cur <= win;
          last <= win;
          we_q <= grant[0] ? fl_we : grant[1] & dm_we;
          ram_addr <= grant[0] ? fl_addr : grant[1] ? dm_addr : if_addr;
          ram_wdata <= grant[0] ? fl_wdata : grant[1] ? dm_wdata : ram_wdata;
          state <= ACCESS;
        end
        ACCESS: begin
          valid_q <= 3'b001 << cur;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    ram_we = we_q & ~reset;
    fl_valid = valid_q[0] & ~reset;
    dm_valid = valid_q[1] & ~reset;
    if_valid = valid_q[2] & ~reset;
    rdata = (state == RESP) ? ram_rdata : '0;
    stall = (dm_req & ~dm_valid) | (if_req & ~if_valid);
  end
endmodule
